// File: rtl/m92_pkg.sv
// Shared M92 loader definitions: ROM region table, board configuration record,
// loader FSM states and the sprite byte-reorder helper.
package m92_pkg;

  typedef struct packed {
    logic [24:0] base_addr;
    logic [4:0]  bram_cs;
    logic        reorder_64;
  } region_t;

  typedef struct packed {
    logic       ext_cfg;
    logic [7:0] game_id;
  } board_cfg_t;

  typedef enum logic [2:0] {
    LS_IDLE,
    LS_IDX,
    LS_LEN,
    LS_DATA,
    LS_WAIT_ACK,
    LS_SKIP,
    LS_CFG
  } load_state_e;

  localparam logic [7:0] CFG_RECORD_IDX = 8'hFF;

  // Entries are listed from index 7 down to index 0.
  localparam region_t [7:0] LOAD_REGIONS = '{
    '{base_addr: 25'h0000000, bram_cs: 5'b01000, reorder_64: 1'b0},
    '{base_addr: 25'h0000000, bram_cs: 5'b00100, reorder_64: 1'b0},
    '{base_addr: 25'h0000000, bram_cs: 5'b00001, reorder_64: 1'b0},
    '{base_addr: 25'h0800000, bram_cs: 5'b00000, reorder_64: 1'b0},
    '{base_addr: 25'h0000000, bram_cs: 5'b00010, reorder_64: 1'b0},
    '{base_addr: 25'h0400000, bram_cs: 5'b00000, reorder_64: 1'b1},
    '{base_addr: 25'h0100000, bram_cs: 5'b00000, reorder_64: 1'b0},
    '{base_addr: 25'h0000000, bram_cs: 5'b00000, reorder_64: 1'b0}
  };

  // Sprite ROMs interleave 64-bit groups: bit 2 of the offset moves to bit 0.
  function automatic logic [24:0] reorder_64_addr(input logic [24:0] offset);
    return {offset[24:3], offset[1:0], offset[2]};
  endfunction

endpackage

// File: rtl/m92_rom_loader.sv
// Parses the ioctl ROM download stream into region records, routing data bytes
// to SDRAM (one outstanding request) or to BRAM, and captures the board config.
module m92_rom_loader
  import m92_pkg::*;
#(
  parameter region_t [7:0] REGIONS = LOAD_REGIONS
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic [24:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic [1:0]  sdr_be,
  output logic        bram_wr,
  output logic [4:0]  bram_cs,
  output logic [24:0] bram_addr,
  output logic [7:0]  bram_data,
  output board_cfg_t  board_cfg,
  output logic        load_done,
  output logic        load_error
);

  // Handshakes: a byte is taken on any cycle with ioctl_wr && !ioctl_wait;
  // sdr_req is held with stable address/data until a cycle with sdr_ack,
  // and sdr_req/ioctl_wait both drop on the following cycle.
  load_state_e state;
  logic        dl_q;
  logic [1:0]  len_cnt;
  logic        cfg_cnt;
  logic        skip;
  logic        abort;
  logic [2:0]  region_idx;
  logic [23:0] length;
  logic [24:0] offset;
  logic [7:0]  cfg_lo;

  region_t     cur;
  logic        accept;
  logic        dl_rise;
  logic        dl_fall;
  logic [24:0] mapped;
  logic [24:0] sdr_next;
  logic [23:0] len_next;

  always_comb begin
    cur      = REGIONS[region_idx];
    accept   = ioctl_wr && !ioctl_wait;
    dl_rise  = ioctl_download && !dl_q;
    dl_fall  = !ioctl_download && dl_q;
    mapped   = cur.reorder_64 ? reorder_64_addr(offset) : offset;
    sdr_next = cur.base_addr + mapped;
    len_next = {length[15:0], ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LS_IDLE;
      dl_q       <= 1'b0;
      len_cnt    <= 2'd0;
      cfg_cnt    <= 1'b0;
      skip       <= 1'b0;
      abort      <= 1'b0;
      region_idx <= 3'd0;
      length     <= 24'd0;
      offset     <= 25'd0;
      cfg_lo     <= 8'd0;
      ioctl_wait <= 1'b0;
      sdr_req    <= 1'b0;
      sdr_addr   <= 25'd0;
      sdr_data   <= 16'd0;
      sdr_be     <= 2'b00;
      bram_wr    <= 1'b0;
      bram_cs    <= 5'd0;
      bram_addr  <= 25'd0;
      bram_data  <= 8'd0;
      board_cfg  <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      dl_q    <= ioctl_download;
      bram_wr <= 1'b0;
      case (state)
        LS_IDLE: begin
          if (dl_rise) begin
            state      <= LS_IDX;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            offset     <= 25'd0;
            length     <= 24'd0;
            skip       <= 1'b0;
            abort      <= 1'b0;
          end
        end

        LS_WAIT_ACK: begin
          // A download that ends here still completes the handshake first.
          if (dl_fall) abort <= 1'b1;
          if (sdr_ack) begin
            sdr_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            if (abort || dl_fall) begin
              state      <= LS_IDLE;
              load_error <= 1'b1;
              abort      <= 1'b0;
            end else if (length == 24'd0) begin
              state <= LS_IDX;
            end else begin
              state <= LS_DATA;
            end
          end
        end

        default: begin
          if (dl_fall) begin
            state <= LS_IDLE;
            if (state == LS_IDX) load_done <= !load_error;
            else                 load_error <= 1'b1;
          end else if (accept) begin
            case (state)
              LS_IDX: begin
                region_idx <= ioctl_dout[2:0];
                len_cnt    <= 2'd0;
                length     <= 24'd0;
                if (ioctl_dout < 8'd8) begin
                  skip  <= 1'b0;
                  state <= LS_LEN;
                end else if (ioctl_dout == CFG_RECORD_IDX) begin
                  cfg_cnt <= 1'b0;
                  state   <= LS_CFG;
                end else begin
                  skip       <= 1'b1;
                  load_error <= 1'b1;
                  state      <= LS_LEN;
                end
              end

              LS_LEN: begin
                length  <= len_next;
                len_cnt <= len_cnt + 2'd1;
                if (len_cnt == 2'd2) begin
                  if (len_next == 24'd0) begin
                    state <= LS_IDX;
                  end else if (skip) begin
                    state <= LS_SKIP;
                  end else begin
                    offset <= 25'd0;
                    state  <= LS_DATA;
                  end
                end
              end

              LS_DATA: begin
                offset <= offset + 25'd1;
                length <= length - 24'd1;
                if (cur.bram_cs != 5'd0) begin
                  bram_wr   <= 1'b1;
                  bram_cs   <= cur.bram_cs;
                  bram_addr <= mapped;
                  bram_data <= ioctl_dout;
                  if (length == 24'd1) state <= LS_IDX;
                end else begin
                  sdr_req    <= 1'b1;
                  ioctl_wait <= 1'b1;
                  sdr_addr   <= sdr_next;
                  sdr_data   <= {ioctl_dout, ioctl_dout};
                  sdr_be     <= {sdr_next[0], ~sdr_next[0]};
                  state      <= LS_WAIT_ACK;
                end
              end

              LS_SKIP: begin
                length <= length - 24'd1;
                if (length == 24'd1) begin
                  skip  <= 1'b0;
                  state <= LS_IDX;
                end
              end

              LS_CFG: begin
                if (!cfg_cnt) begin
                  cfg_lo  <= ioctl_dout;
                  cfg_cnt <= 1'b1;
                end else begin
                  board_cfg <= board_cfg_t'({ioctl_dout[0], cfg_lo});
                  state     <= LS_IDX;
                end
              end

              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m92_rom_loader.sv
// Directed bench for m92_rom_loader: table-driven data bytes with a scoreboard
// for SDRAM/BRAM writes, plus hand-written abort, skip and reset sequences.
module tb_m92_rom_loader;
  import m92_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic        sdr_req;
  logic        sdr_ack;
  logic [24:0] sdr_addr;
  logic [15:0] sdr_data;
  logic [1:0]  sdr_be;
  logic        bram_wr;
  logic [4:0]  bram_cs;
  logic [24:0] bram_addr;
  logic [7:0]  bram_data;
  board_cfg_t  board_cfg;
  logic        load_done;
  logic        load_error;

  logic resp_ack = 1'b0;
  logic man_ack  = 1'b0;
  assign sdr_ack = resp_ack | man_ack;

  m92_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .sdr_req        (sdr_req),
    .sdr_ack        (sdr_ack),
    .sdr_addr       (sdr_addr),
    .sdr_data       (sdr_data),
    .sdr_be         (sdr_be),
    .bram_wr        (bram_wr),
    .bram_cs        (bram_cs),
    .bram_addr      (bram_addr),
    .bram_data      (bram_data),
    .board_cfg      (board_cfg),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [42:0] exp_q[$];    // {sdr_addr, sdr_data, sdr_be}
  logic [37:0] exp_b_q[$];  // {bram_cs, bram_addr, bram_data}
  int req_rises = 0;
  int bram_pulses = 0;
  int wait_cycles = 0;
  int ack_lat = 3;
  bit ack_en = 1'b1;
  bit wait_chk = 1'b1;

  typedef struct {
    logic [7:0]  din;
    logic [24:0] addr;
    logic [1:0]  be;
    logic        to_bram;
    logic [4:0]  cs;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // ---------------- monitor: SDRAM and BRAM scoreboard ----------------
  initial begin : monitor
    logic        req_prev;
    logic [42:0] cap;
    logic [42:0] e;
    logic [37:0] eb;
    bit          stable;
    int          run;
    req_prev = 1'b0;
    cap = '0;
    stable = 1'b1;
    run = 0;
    forever begin
      @(posedge clk_sys); #1;
      if (sdr_req && !req_prev) begin
        req_rises++;
        cap = {sdr_addr, sdr_data, sdr_be};
        stable = 1'b1;
        check("req_wait_rise", ioctl_wait, 1'b1);
        if (exp_q.size() == 0) begin
          fail_now("sdr_unexpected_req");
        end else begin
          e = exp_q.pop_front();
          check("sdr_write", {sdr_addr, sdr_data, sdr_be}, e);
        end
      end else if (sdr_req && ({sdr_addr, sdr_data, sdr_be} != cap)) begin
        stable = 1'b0;
      end
      if (!sdr_req && req_prev) begin
        check("sdr_stable", stable, 1'b1);
        check("wait_drop", ioctl_wait, 1'b0);
      end
      req_prev = sdr_req;

      if (ioctl_wait) begin
        run++;
        wait_cycles++;
      end else if (run > 0) begin
        if (wait_chk) check("wait_run", run, ack_lat + 1);
        run = 0;
      end

      if (bram_wr) begin
        bram_pulses++;
        if (exp_b_q.size() == 0) begin
          fail_now("bram_unexpected_wr");
        end else begin
          eb = exp_b_q.pop_front();
          check("bram_write", {bram_cs, bram_addr, bram_data}, eb);
        end
      end
    end
  end

  // ---------------- SDRAM responder ----------------
  initial begin : responder
    forever begin
      @(posedge clk_sys); #1;
      if (sdr_req && ack_en) begin
        repeat (ack_lat) begin
          @(posedge clk_sys); #1;
        end
        resp_ack = 1'b1;
        @(posedge clk_sys); #1;
        resp_ack = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (ioctl_wait && n < 200) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (n >= 200) fail_now("send_byte_wait");
    ioctl_dout = b;
    ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] idx, input logic [23:0] len);
    send_byte(idx);
    send_byte(len[23:16]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sdr_req || ioctl_wait) && n < 200) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (n >= 200) fail_now("wait_idle");
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic end_dl();
    wait_idle();
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic apply_group(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (vecs[i].to_bram)
        exp_b_q.push_back({vecs[i].cs, vecs[i].addr, vecs[i].din});
      else
        exp_q.push_back({vecs[i].addr, {vecs[i].din, vecs[i].din}, vecs[i].be});
      send_byte(vecs[i].din);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- main test ----------------
  initial begin : main
    int r0;
    int b0;
    int w0;

    // Region 0: CPU ROM at SDRAM 0, linear
    vecs[0]  = '{8'h11, 25'h0000000, 2'b01, 1'b0, 5'd0};
    vecs[1]  = '{8'h22, 25'h0000001, 2'b10, 1'b0, 5'd0};
    vecs[2]  = '{8'h33, 25'h0000002, 2'b01, 1'b0, 5'd0};
    vecs[3]  = '{8'h44, 25'h0000003, 2'b10, 1'b0, 5'd0};
    // Region 2: sprites at 0x400000, byte k -> {k[1:0], k[2]}
    vecs[4]  = '{8'h00, 25'h0400000, 2'b01, 1'b0, 5'd0};
    vecs[5]  = '{8'h01, 25'h0400002, 2'b01, 1'b0, 5'd0};
    vecs[6]  = '{8'h02, 25'h0400004, 2'b01, 1'b0, 5'd0};
    vecs[7]  = '{8'h03, 25'h0400006, 2'b01, 1'b0, 5'd0};
    vecs[8]  = '{8'h04, 25'h0400001, 2'b10, 1'b0, 5'd0};
    vecs[9]  = '{8'h05, 25'h0400003, 2'b10, 1'b0, 5'd0};
    vecs[10] = '{8'h06, 25'h0400005, 2'b10, 1'b0, 5'd0};
    vecs[11] = '{8'h07, 25'h0400007, 2'b10, 1'b0, 5'd0};
    // Region 3: sound BRAM, chip select 00010
    vecs[12] = '{8'hA1, 25'h0000000, 2'b00, 1'b1, 5'b00010};
    vecs[13] = '{8'hB2, 25'h0000001, 2'b00, 1'b1, 5'b00010};
    vecs[14] = '{8'hC3, 25'h0000002, 2'b00, 1'b1, 5'b00010};

    // reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_ioctl_wait", ioctl_wait, 1'b0);
    check("rst_sdr_req", sdr_req, 1'b0);
    check("rst_bram_wr", bram_wr, 1'b0);
    check("rst_flags", {load_done, load_error}, 2'b00);
    check("rst_board_cfg", board_cfg, 9'h000);
    check("rst_addr_data", {sdr_addr, sdr_data, sdr_be, bram_cs, bram_addr, bram_data}, '0);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // download 1: region 0, ack latency 3
    ack_lat = 3;
    start_dl();
    send_hdr(8'h00, 24'd4);
    apply_group(0, 3);
    end_dl();
    check("dl1_done", load_done, 1'b1);
    check("dl1_error", load_error, 1'b0);

    // download 2: sprites, BRAM region, config, empty record
    start_dl();
    check("dl2_done_cleared", load_done, 1'b0);
    ack_lat = 0;
    send_hdr(8'h02, 24'd8);
    apply_group(4, 11);
    wait_idle();
    r0 = req_rises;
    w0 = wait_cycles;
    b0 = bram_pulses;
    send_hdr(8'h03, 24'd3);
    apply_group(12, 14);
    @(posedge clk_sys); #1;
    check("bram_pulses", bram_pulses - b0, 3);
    check("bram_no_req", req_rises - r0, 0);
    check("bram_no_wait", wait_cycles - w0, 0);

    send_byte(8'hFF);
    send_byte(8'h5A);
    send_byte(8'h01);
    check("board_cfg", board_cfg, 9'h15A);

    ack_lat = 2;
    r0 = req_rises;
    b0 = bram_pulses;
    send_hdr(8'h01, 24'd0);
    send_hdr(8'h00, 24'd1);
    exp_q.push_back({25'h0000000, 16'h5555, 2'b01});
    send_byte(8'h55);
    wait_idle();
    check("len0_req_count", req_rises - r0, 1);
    check("len0_bram_count", bram_pulses - b0, 0);
    end_dl();
    check("dl2_done", load_done, 1'b1);
    check("dl2_cfg_kept", board_cfg, 9'h15A);

    // download 3: bad index skipped, later region still written
    start_dl();
    send_byte(8'hFA);
    check("bad_idx_error", load_error, 1'b1);
    r0 = req_rises;
    b0 = bram_pulses;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(posedge clk_sys); #1;
    check("skip_no_req", req_rises - r0, 0);
    check("skip_no_bram", bram_pulses - b0, 0);
    send_hdr(8'h00, 24'd1);
    exp_q.push_back({25'h0000000, 16'h6666, 2'b01});
    send_byte(8'h66);
    end_dl();
    check("dl3_done", load_done, 1'b0);
    check("dl3_error", load_error, 1'b1);

    // download 4: download falls with a request pending and 2 bytes left
    wait_chk = 1'b0;
    ack_lat = 1;
    start_dl();
    check("dl4_error_cleared", load_error, 1'b0);
    send_hdr(8'h00, 24'd4);
    exp_q.push_back({25'h0000000, 16'h1111, 2'b01});
    send_byte(8'h11);
    wait_idle();
    ack_en = 1'b0;
    exp_q.push_back({25'h0000001, 16'h2222, 2'b10});
    send_byte(8'h22);
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("abort_req_held", sdr_req, 1'b1);
    check("abort_wait_held", ioctl_wait, 1'b1);
    check("abort_addr_held", sdr_addr, 25'h0000001);
    man_ack = 1'b1;
    @(posedge clk_sys); #1;
    man_ack = 1'b0;
    check("abort_req_drop", sdr_req, 1'b0);
    check("abort_wait_drop", ioctl_wait, 1'b0);
    check("abort_flags", {load_done, load_error}, 2'b01);

    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    check("rerise_flags", {load_done, load_error}, 2'b00);

    // reset in the middle of a pending request
    send_hdr(8'h00, 24'd2);
    exp_q.push_back({25'h0000000, 16'h3333, 2'b01});
    send_byte(8'h33);
    @(posedge clk_sys); #1;
    check("pre_reset_req", sdr_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check("reset_req_drop", sdr_req, 1'b0);
    check("reset_wait_drop", ioctl_wait, 1'b0);
    check("reset_board_cfg", board_cfg, 9'h000);
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check("post_reset_idle", {sdr_req, ioctl_wait, load_done, load_error}, 4'b0000);

    check("sdr_queue_empty", exp_q.size(), 0);
    check("bram_queue_empty", exp_b_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m92_rom_loader.md
# m92_rom_loader

Parses the MiSTer ioctl ROM download stream into per-region records and routes each data byte to SDRAM or to an on-chip BRAM. Region placement comes from the shared region table in `m92_pkg`. Also captures the board configuration record. Sits between `hps_io` (upstream) and the SDRAM arbiter / BRAM write ports (downstream).

## Interface
Parameters:
- `REGIONS`, `m92_pkg::LOAD_REGIONS`: 8-entry region table, indexed by record index.

Ports:
- `clk_sys` in 1: single clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `ioctl_download` in 1: download window.
- `ioctl_wr` in 1: byte strobe.
- `ioctl_dout` in 8: stream byte.
- `ioctl_wait` out 1: stall request to `hps_io`.
- `sdr_req` out 1: SDRAM write request, held until ack.
- `sdr_ack` in 1: one-cycle acknowledge.
- `sdr_addr` out 25: byte address.
- `sdr_data` out 16: byte duplicated in both halves.
- `sdr_be` out 2: one-hot byte enable, equal to {a[0], ~a[0]}.
- `bram_wr` out 1: one-cycle BRAM write strobe.
- `bram_cs` out 5: region `bram_cs`.
- `bram_addr` out 25: byte offset within the region.
- `bram_data` out 8: BRAM write data.
- `board_cfg` out 9: `m92_pkg::board_cfg_t`, captured value.
- `load_done` out 1: level; clean stream completed.
- `load_error` out 1: level; malformed stream.

## Operation
- Stream format:
  - Region record: idx byte (0–7), 24-bit length (big-endian, 3 bytes), then length data bytes.
  - Config record: idx 0xFF, then 2 bytes little-endian; cfg = {b1[0], b0}.
- States: IDLE, IDX, LEN (2-bit byte counter), DATA, WAIT_ACK, SKIP, CFG (1-bit counter).
- IDLE:
  - On `ioctl_download` rising → IDX.
  - On the same edge, clear `load_done`, `load_error`, offset and length.
- IDX:
  - idx < 8 → LEN.
  - idx == 0xFF → CFG.
  - Any other idx → LEN, with a skip flag set and `load_error` set.
- LEN:
  - Shifts in three bytes.
  - After the third byte: length 0 → IDX; skip flag → SKIP; otherwise → DATA, with offset = 0.
- DATA byte accepted (`ioctl_wr` && !`ioctl_wait`):
  - Compute mapped offset m.
  - `reorder_64`=0: m = offset.
  - `reorder_64`=1: m = {offset[24:3], offset[1:0], offset[2]}.
  - `bram_cs` ≠ 0: pulse `bram_wr` with `bram_addr` = m. Stay in DATA; no stall.
  - `bram_cs` = 0: `sdr_addr` = `base_addr` + m (25-bit, wraps modulo 2^25); raise `sdr_req`; → WAIT_ACK.
  - In both cases: offset += 1, length −= 1.
  - When length reaches 0 → IDX (from DATA, or from WAIT_ACK after the ack).
- WAIT_ACK:
  - `ioctl_wait` = 1.
  - On `sdr_ack`: drop `sdr_req`, then return to DATA or IDX.
- SKIP: consumes length bytes with no writes, then → IDX.
- CFG: after the second byte, latch `board_cfg` → IDX.
- `ioctl_download` falling:
  - → IDLE.
  - If the falling edge arrives in LEN, DATA, SKIP or CFG with bytes still expected: `load_error` = 1, `load_done` stays 0.
  - If it arrives in WAIT_ACK: finish the handshake first (hold `sdr_req` until ack), then → IDLE with `load_error` = 1.
  - Otherwise: `load_done` = 1 unless `load_error` is already set.
- Bytes arriving while in IDLE are ignored.

## Timing
- Reset values:
  - `ioctl_wait`, `sdr_req`, `bram_wr`, `load_done`, `load_error` = 0.
  - `board_cfg` = 0.
  - All address/data outputs = 0.
  - State = IDLE.
- All outputs are registered.
- Accept is the cycle with `ioctl_wr` && !`ioctl_wait`. Write outputs are valid the following cycle:
  - BRAM path: `bram_wr` high for exactly that one cycle.
  - SDRAM path: `sdr_req` and `ioctl_wait` rise together that cycle.
- `sdr_ack` arriving the cycle `sdr_req` rises is accepted. Both `sdr_req` and `ioctl_wait` drop the cycle after the ack.
- The earliest next SDRAM request is 2 cycles after the ack.
- `sdr_addr`, `sdr_data` and `sdr_be` are stable while `sdr_req` is high.
- Only one SDRAM request is ever outstanding.
- `ioctl_wr` asserted while `ioctl_wait` is high is ignored.
- `reset_n` low mid-transfer: immediate return to reset values. Any pending request is abandoned.

## Structure
- `region_t`, `board_cfg_t` and `LOAD_REGIONS` stay in `m92_pkg`.
- Add to `m92_pkg`:
  - function `reorder_64_addr(offset)` for the offset mapping above.
  - constant `CFG_RECORD_IDX` = 8'hFF.
- Single module, no sub-module: the FSM with the length/offset counters is small enough.

## Test plan
- Region 0 (CPU ROM), length 4, bytes 11 22 33 44, ack latency 3:
  - 4 SDRAM writes at addr 0..3, `sdr_be` 01,10,01,10, `sdr_data` 1111/2222/3333/4444.
  - `ioctl_wait` high 4 cycles per byte.
  - `load_done` = 1 after the download falls.
- Region 2 (sprite, `reorder_64`), 8 bytes 00..07:
  - Byte k written to 0x400000 + {k[1:0], k[2]}.
  - Byte 1 → 0x400002, byte 4 → 0x400001, byte 7 → 0x400007.
- Region 3 (sound, `bram_cs` 00010), length 3, ack tied low:
  - 3 single-cycle `bram_wr` pulses, `bram_addr` 0,1,2, `bram_cs` = 00010.
  - `sdr_req` never rises; `ioctl_wait` stays 0.
- Record FF 5A 01: `board_cfg` = 9'h15A. Length-0 record for region 1 → no writes; the parser accepts the next idx.
- Stream FA 00 00 02 AA BB followed by region 0, length 1:
  - First record skipped, `load_error` = 1.
  - Region 0 byte still written at addr 0.
  - `load_done` = 0 at the end.
- Download falls mid-DATA, with 2 bytes remaining and `sdr_req` pending:
  - Request held until ack, then IDLE with `load_error` = 1.
  - A new download rise clears both flags.
  - `reset_n` pulsed mid-WAIT_ACK drops `sdr_req` immediately.
